icache_refill_responder: RTL and testbench
==========================================

ICACHE_REFILL_RESPONDER -- requirements
Module: icache_refill_responder

Interface
REQ-001 SHALL have parameter ADDR_W, 32, request address width.
REQ-002 SHALL have parameter ENTRY_W, 4, MSHR entry id width.
REQ-003 SHALL have parameter LINE_W, 256, refill line width (8 x 32-bit words).
REQ-004 SHALL have parameter DEPTH, 4, request queue depth (power of two).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port downstream_txreq_vld  input  1  refill request valid from icache.
REQ-008 SHALL have port downstream_txreq_rdy  output  1  queue can accept.
REQ-009 SHALL have port downstream_txreq_pld  input  ADDR_W  refill address.
REQ-010 SHALL have port downstream_txreq_entry_id  input  ENTRY_W  MSHR entry tag.
REQ-011 SHALL have port downstream_rxdat_vld  output  1  refill data valid to icache.
REQ-012 SHALL have port downstream_rxdat_rdy  input  1  icache accepts data.
REQ-013 SHALL have port downstream_rxdat_pld  output  ENTRY_W+LINE_W  {entry_id, line data}.
REQ-014 SHALL have port rsp_latency  input  4  extra wait cycles per response, quasi-static.
REQ-015 SHALL have port outstanding  output  $clog2(DEPTH)+1  requests held (queued plus in service).

Function
REQ-016 SHALL hold requests in an in-order FIFO of DEPTH entries {addr, entry_id}; push on txreq_vld && txreq_rdy.
REQ-017 SHALL drive txreq_rdy = (FIFO count < DEPTH), combinationally from registered count only; no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-018 SHALL sequence the FIFO head with FSM states IDLE, WAIT, SEND.
REQ-019 IDLE: if FIFO non-empty -> WAIT, counter loaded with rsp_latency (sampled this cycle); else stay.
REQ-020 WAIT: counter==0 -> SEND; else counter decrements by 1.
REQ-021 SEND: rxdat_vld=1, pld from FIFO head; on rxdat_rdy pop head and -> IDLE; else hold vld and pld stable.
REQ-022 SHALL assert rxdat_vld only in SEND; accept in cycle T gives earliest rxdat_vld in cycle T+rsp_latency+3 (empty FIFO, IDLE).
REQ-023 Line data SHALL be deterministic: base = addr with low 5 bits cleared; word i (bits 32i+31:32i, i=0..7) = base + 4*i, modulo 2^32.
REQ-024 pld[ENTRY_W+LINE_W-1:LINE_W] SHALL equal the stored entry_id.
REQ-025 Responses SHALL return in acceptance order; entry_id passes through unmodified.
REQ-026 outstanding SHALL equal FIFO count; simultaneous push and pop leave it unchanged.
REQ-027 rsp_latency changes SHALL affect only responses whose WAIT begins afterwards.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH without loss or duplication.

Reset
REQ-029 On rst_n low, immediately: FSM=IDLE, FIFO empty, counter=0, rxdat_vld=0, outstanding=0, txreq_rdy=0 while rst_n low, 1 from first cycle after release.
REQ-030 Reset mid-response SHALL discard all queued and in-service requests; no response is issued for them after release.
REQ-031 rxdat_pld SHALL read 0 when FIFO empty.

Verification
REQ-032 Single request addr=0x0000_1234, id=3, rsp_latency=0, rdy=1 -> vld 3 cycles after accept, id=3, word0=0x0000_1220, word7=0x0000_123C.
REQ-033 Four back-to-back requests ids 0..3, rxdat_rdy=0 -> txreq_rdy low after 4th, outstanding=4, fifth request not accepted; release rdy -> ids 0,1,2,3 in order.
REQ-034 rsp_latency=5, one request -> vld exactly 8 cycles after accept; with rdy held low 10 cycles, vld and pld stable throughout.
REQ-035 addr=0xFFFF_FFF0 -> word0=0xFFFF_FFE0, word1=0xFFFF_FFE4, word7=0xFFFF_FFFC; no overflow into other bits.
REQ-036 Ten requests with random rdy throttling across pointer wrap -> ten responses, order and ids match, outstanding returns to 0.
REQ-037 Assert rst_n low while in SEND with 3 queued -> vld drops immediately, outstanding=0; after release no stale response appears within 20 cycles.

Source files
------------

// File: rtl/icache_refill_responder.sv
// Refill responder: queues icache refill requests in order and, after a programmable
// delay, returns a synthetic 8-word line whose words count up from the line base address.
module icache_refill_responder #(
  parameter int ADDR_W  = 32,
  parameter int ENTRY_W = 4,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        downstream_txreq_vld,
  output logic                        downstream_txreq_rdy,
  input  logic [ADDR_W-1:0]           downstream_txreq_pld,
  input  logic [ENTRY_W-1:0]          downstream_txreq_entry_id,
  output logic                        downstream_rxdat_vld,
  input  logic                        downstream_rxdat_rdy,
  output logic [ENTRY_W+LINE_W-1:0]   downstream_rxdat_pld,
  input  logic [3:0]                  rsp_latency,
  output logic [$clog2(DEPTH):0]      outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WORDS = LINE_W / 32;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  mem_addr_q [DEPTH];
  logic [ENTRY_W-1:0] mem_id_q   [DEPTH];

  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  head_addr;
  logic [ENTRY_W-1:0] head_id;
  logic [31:0]        base_w;
  logic [LINE_W-1:0]  line_w;

  // Ready looks only at the registered count, so a full queue never accepts even
  // in a cycle where the head is popped.
  assign downstream_txreq_rdy = rst_n && (count_q < CNT_W'(DEPTH));
  assign push                 = downstream_txreq_vld && downstream_txreq_rdy;
  assign pop                  = (state_q == SEND) && downstream_rxdat_rdy;
  assign outstanding          = count_q;
  assign downstream_rxdat_vld = vld_q;

  assign head_addr = mem_addr_q[rd_ptr_q];
  assign head_id   = mem_id_q[rd_ptr_q];
  assign base_w    = 32'(head_addr) & 32'hFFFF_FFE0;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign line_w[32*gi +: 32] = base_w + 32'(4 * gi);
    end
  endgenerate

  assign downstream_rxdat_pld = (count_q == '0) ? '0 : {head_id, line_w};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= downstream_txreq_pld;
      mem_id_q[wr_ptr_q]   <= downstream_txreq_entry_id;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WAIT;
          cnt_d   = rsp_latency;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = SEND;
        else             cnt_d   = cnt_q - 4'd1;
      end
      SEND: begin
        if (downstream_rxdat_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Valid is registered alongside the state so it is high exactly in SEND.
    vld_d = (state_d == SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed scoreboard bench for icache_refill_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares every accepted response.
module tb_icache_refill_responder;
  localparam int ADDR_W  = 32;
  localparam int ENTRY_W = 4;
  localparam int LINE_W  = 256;
  localparam int DEPTH   = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      txreq_vld = 1'b0;
  logic                      txreq_rdy;
  logic [ADDR_W-1:0]         txreq_pld = '0;
  logic [ENTRY_W-1:0]        txreq_id = '0;
  logic                      rxdat_vld;
  logic                      rxdat_rdy = 1'b0;
  logic [ENTRY_W+LINE_W-1:0] rxdat_pld;
  logic [3:0]                rsp_latency = 4'd0;
  logic [$clog2(DEPTH):0]    outstanding;

  icache_refill_responder #(
    .ADDR_W(ADDR_W), .ENTRY_W(ENTRY_W), .LINE_W(LINE_W), .DEPTH(DEPTH)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .downstream_txreq_vld      (txreq_vld),
    .downstream_txreq_rdy      (txreq_rdy),
    .downstream_txreq_pld      (txreq_pld),
    .downstream_txreq_entry_id (txreq_id),
    .downstream_rxdat_vld      (rxdat_vld),
    .downstream_rxdat_rdy      (rxdat_rdy),
    .downstream_rxdat_pld      (rxdat_pld),
    .rsp_latency               (rsp_latency),
    .outstanding               (outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cnt = 0;
  logic [ENTRY_W+LINE_W-1:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LINE_W-1:0] make_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [31:0] b;
    b = a & 32'hFFFF_FFE0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = b + 32'(4 * i);
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake on the response side is checked in order.
  always @(negedge clk) begin
    if (rst_n && rxdat_vld && rxdat_rdy) begin
      checks++;
      resp_cnt++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=%0h required=none", rxdat_pld);
      end else begin
        logic [ENTRY_W+LINE_W-1:0] exp;
        exp = sb_q.pop_front();
        if (rxdat_pld !== exp) begin
          errors++;
          $display("FAIL rsp_pld actual=%0h required=%0h", rxdat_pld, exp);
        end else begin
          $display("RSP %0d id=%0h word0=%08h ok", resp_cnt, rxdat_pld[LINE_W +: ENTRY_W], rxdat_pld[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input logic [31:0] a, input logic [3:0] id);
    int n;
    n = 0;
    txreq_vld = 1'b1;
    txreq_pld = a;
    txreq_id  = id;
    while (1) begin
      @(negedge clk);
      if (txreq_rdy) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=rdy_low required=rdy_high id=%0h", id);
        break;
      end
    end
    if (n <= 200) begin
      acc_cyc = cyc;
      sb_q.push_back({id, make_line(a)});
    end
    step();
    txreq_vld = 1'b0;
  endtask

  task automatic wait_vld(input string name, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < 100) begin
      @(negedge clk);
      if (rxdat_vld) begin
        at = cyc;
        break;
      end
      n++;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_vld required=vld", name);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || outstanding != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_outstanding"}, 64'(outstanding), 64'd0);
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int at;
    int base_cnt;
    int stale;
    logic [ENTRY_W+LINE_W-1:0] p0;

    // Reset state
    #1;
    chk("rst_vld", 64'(rxdat_vld), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_txreq_rdy", 64'(txreq_rdy), 64'd0);
    chk("rst_pld_zero", 64'(rxdat_pld == '0), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(txreq_rdy), 64'd1);

    // Single request, zero latency
    step();
    rxdat_rdy   = 1'b1;
    rsp_latency = 4'd0;
    send_req(32'h0000_1234, 4'd3);
    wait_vld("single_vld", at);
    chk("single_latency", 64'(at - acc_cyc), 64'd3);
    chk("single_id", 64'(rxdat_pld[LINE_W +: ENTRY_W]), 64'd3);
    chk("single_word0", 64'(rxdat_pld[31:0]), 64'h0000_1220);
    chk("single_word7", 64'(rxdat_pld[255:224]), 64'h0000_123C);
    drain("single");

    // Fill the queue with the response side stalled
    step();
    rxdat_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_req(32'h0000_4000 + 32'(i * 32), 4'(i));
    @(negedge clk);
    chk("full_rdy_low", 64'(txreq_rdy), 64'd0);
    chk("full_outstanding", 64'(outstanding), 64'd4);
    step();
    txreq_vld = 1'b1;
    txreq_pld = 32'h0000_9000;
    txreq_id  = 4'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_reject_rdy", 64'(txreq_rdy), 64'd0);
    end
    step();
    chk("full_reject_outstanding", 64'(outstanding), 64'd4);
    txreq_vld = 1'b0;
    rxdat_rdy = 1'b1;
    drain("full");

    // Latency 5 with a stalled consumer
    step();
    rxdat_rdy   = 1'b0;
    rsp_latency = 4'd5;
    send_req(32'h0000_2468, 4'd5);
    wait_vld("lat5_vld", at);
    chk("lat5_latency", 64'(at - acc_cyc), 64'd8);
    p0 = rxdat_pld;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (!rxdat_vld || rxdat_pld !== p0) begin
        errors++;
        $display("FAIL lat5_stable cyc=%0d actual_vld=%0b actual=%0h required=%0h", k, rxdat_vld, rxdat_pld, p0);
      end
    end
    step();
    rxdat_rdy   = 1'b1;
    rsp_latency = 4'd0;
    drain("lat5");

    // Address near the top of the space
    step();
    send_req(32'hFFFF_FFF0, 4'd7);
    wait_vld("top_vld", at);
    chk("top_word0", 64'(rxdat_pld[31:0]), 64'hFFFF_FFE0);
    chk("top_word1", 64'(rxdat_pld[63:32]), 64'hFFFF_FFE4);
    chk("top_word7", 64'(rxdat_pld[255:224]), 64'hFFFF_FFFC);
    chk("top_id", 64'(rxdat_pld[LINE_W +: ENTRY_W]), 64'd7);
    drain("top");

    // Ten requests under random consumer throttling, crossing the pointer wrap
    step();
    base_cnt = resp_cnt;
    rsp_latency = 4'd1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_req(32'h0001_0000 + 32'(i * 'h44), 4'(i + 4));
      end
      begin
        for (int k = 0; k < 60; k++) begin
          step();
          rxdat_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    rxdat_rdy = 1'b1;
    drain("wrap");
    chk("wrap_resp_count", 64'(resp_cnt - base_cnt), 64'd10);

    // Reset while a response is being presented with more queued
    step();
    rxdat_rdy   = 1'b0;
    rsp_latency = 4'd0;
    for (int i = 0; i < 3; i++) send_req(32'h0002_0000 + 32'(i * 32), 4'(i + 10));
    wait_vld("rstmid_vld", at);
    chk("rstmid_pre_outstanding", 64'(outstanding), 64'd3);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rstmid_vld_drop", 64'(rxdat_vld), 64'd0);
    chk("rstmid_outstanding", 64'(outstanding), 64'd0);
    chk("rstmid_txreq_rdy", 64'(txreq_rdy), 64'd0);
    step();
    step();
    rst_n     = 1'b1;
    rxdat_rdy = 1'b1;
    @(negedge clk);
    chk("rstmid_rdy_after", 64'(txreq_rdy), 64'd1);
    chk("rstmid_pld_empty", 64'(rxdat_pld == '0), 64'd1);
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rxdat_vld) stale++;
    end
    chk("rstmid_no_stale", 64'(stale), 64'd0);
    chk("rstmid_final_outstanding", 64'(outstanding), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
